// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD line-buffer arbiter.
package lcd_arb_pkg;

    localparam int LCD_COLS = 16;
    localparam int CHAR_W = 8;
    localparam int LINE_W = 128;
    localparam logic [CHAR_W-1:0] SPACE_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // A line of all spaces, used as the reset/cleared frame.
    function automatic logic [LINE_W-1:0] blank_line();
        return {LCD_COLS{SPACE_CHAR}};
    endfunction

endpackage

// File: rtl/lcd_buf_arbiter_if.sv
// Request/write/frame bundle between the requesters and lcd_buf_arbiter.
// master = requester side, slave = arbiter side.
interface lcd_buf_arbiter_if
    import lcd_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req_in;
    logic [NUM_REQ-1:0]   wr_en_in;
    logic [NUM_REQ-1:0]   wr_row_in;
    logic [4*NUM_REQ-1:0] wr_col_in;
    logic [8*NUM_REQ-1:0] wr_char_in;
    logic [NUM_REQ-1:0]   gnt_out;
    logic [LINE_W-1:0]    line1_out;
    logic [LINE_W-1:0]    line2_out;
    logic                 upd_out;
    logic                 timeout_out;

    modport master (
        output req_in, wr_en_in, wr_row_in, wr_col_in, wr_char_in,
        input  gnt_out, line1_out, line2_out, upd_out, timeout_out
    );

    modport slave (
        input  req_in, wr_en_in, wr_row_in, wr_col_in, wr_char_in,
        output gnt_out, line1_out, line2_out, upd_out, timeout_out
    );
endinterface

// File: rtl/lcd_buf_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set request
// at or after rr_ptr (wrapping) as a one-hot vector.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     pick,
    output logic             valid
);

    // Scan N positions starting at rr_ptr and keep the first hit.
    always_comb begin
        int j;
        j = 0;
        pick = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                pick[j] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_buf_arbiter.sv
// lcd_buf_arbiter: round-robin owner of the two LCD line buffers.
// Optional grant timeout compiled in with LCD_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no owner; grant the next requester at/after rr_ptr
//   GRANT | owner may write characters; leaves on req drop (or timeout)
//   TURN  | one all-zero grant cycle; upd/timeout pulses live here
module lcd_buf_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int HOLD_MAX = 64
) (
    input  logic clk_in,
    input  logic rst_in,
    lcd_buf_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_MAX < 2) begin : g_param_check
        $error("lcd_buf_arbiter: NUM_REQ must be 2..8 and HOLD_MAX >= 2");
    end

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [LINE_W-1:0]  line1_q, line1_d;
    logic [LINE_W-1:0]  line2_q, line2_d;
    logic               dirty_q, dirty_d;
    logic               upd_q, upd_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               wr_accept;
    logic               wr_row;
    logic [3:0]         wr_col;
    logic [CHAR_W-1:0]  wr_char;
    logic               owner_req;
    logic               hold_expired;

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .req    (bus.req_in),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .valid  (pick_valid)
    );

    // One-hot pick to owner index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    assign owner_req = bus.req_in[owner_q];
    assign wr_row    = bus.wr_row_in[owner_q];
    assign wr_col    = bus.wr_col_in[int'(owner_q)*4 +: 4];
    assign wr_char   = bus.wr_char_in[int'(owner_q)*8 +: 8];
    assign wr_accept = (state_q == GRANT) && gnt_q[owner_q] && bus.wr_en_in[owner_q];

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign hold_expired = (state_q == GRANT) && (hold_q == HOLD_W'(HOLD_MAX - 1));

    // Hold counter: zero outside a grant, counts grant cycles, saturates.
    always_comb begin
        hold_d = hold_q;
        if (state_q != GRANT) hold_d = '0;
        else if (hold_q != '1) hold_d = hold_q + 1'b1;
    end

    // Hold counter register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) hold_q <= '0;
        else        hold_q <= hold_d;
    end
`else
    assign hold_expired = 1'b0;
`endif

    // Next-state, grant, frame-write and pulse logic.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        line1_d   = line1_q;
        line2_d   = line2_q;
        dirty_d   = dirty_q;
        upd_d     = 1'b0;
        timeout_d = 1'b0;

        if (wr_accept) begin
            if (wr_row) line2_d[int'(wr_col)*CHAR_W +: CHAR_W] = wr_char;
            else        line1_d[int'(wr_col)*CHAR_W +: CHAR_W] = wr_char;
            dirty_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    dirty_d = 1'b0;
                end
            end
            GRANT: begin
                // A write in the release cycle still counts toward upd.
                if (!owner_req || hold_expired) begin
                    state_d   = TURN;
                    gnt_d     = '0;
                    upd_d     = dirty_q | wr_accept;
                    timeout_d = hold_expired & owner_req;
                    rr_ptr_d  = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset blanks the frame.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            line1_q   <= blank_line();
            line2_q   <= blank_line();
            dirty_q   <= 1'b0;
            upd_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            line1_q   <= line1_d;
            line2_q   <= line2_d;
            dirty_q   <= dirty_d;
            upd_q     <= upd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt_out     = gnt_q;
    assign bus.line1_out   = line1_q;
    assign bus.line2_out   = line2_q;
    assign bus.upd_out     = upd_q;
    assign bus.timeout_out = timeout_q;

endmodule
